// File: rtl/pipelined_approx_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_approx_adder
// Brief    : Valid/ready pipelined ripple-carry adder with an optional
//            lower-part-OR approximation of the low APPROX_BITS bits.
// Revision : 1.0
// ============================================================================
module pipelined_approx_adder #(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 4,
    parameter int APPROX_BITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic             carry_i,
    input  logic             approx_en_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o
);

    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] mode_q,  mode_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_v, src_m, src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];

    // A stage accepts whenever it is empty or its successor is accepting.
    always_comb begin
        load = '0;
        load[STAGES-1] = !valid_q[STAGES-1] || ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = !valid_q[k] || load[k+1];
        end
    end

    always_comb begin
        src_v    = '0;
        src_m    = '0;
        src_c    = '0;
        src_v[0] = valid_i;
        src_m[0] = approx_en_i;
        src_c[0] = carry_i & ~approx_en_i;
        src_a[0] = add1_i;
        src_b[0] = add2_i;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = valid_q[k-1];
            src_m[k] = mode_q[k-1];
            src_c[k] = carry_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = sum_q[k-1];
        end
    end

    always_comb begin
        logic             c;
        logic [WIDTH-1:0] s;
        c       = 1'b0;
        s       = '0;
        valid_d = valid_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        for (int k = 0; k < STAGES; k++) begin
            c = src_c[k];
            s = src_s[k];
            for (int j = 0; j < CHUNK; j++) begin
                // Below the approximation boundary: OR for the sum, AND feeds the carry.
                if (src_m[k] && ((k * CHUNK + j) < APPROX_BITS)) begin
                    s[k*CHUNK+j] = src_a[k][k*CHUNK+j] | src_b[k][k*CHUNK+j];
                    c            = src_a[k][k*CHUNK+j] & src_b[k][k*CHUNK+j];
                end else begin
                    s[k*CHUNK+j] = src_a[k][k*CHUNK+j] ^ src_b[k][k*CHUNK+j] ^ c;
                    c            = (src_a[k][k*CHUNK+j] & src_b[k][k*CHUNK+j]) |
                                   (c & (src_a[k][k*CHUNK+j] ^ src_b[k][k*CHUNK+j]));
                end
            end

            valid_d[k] = load[k] ? src_v[k] : valid_q[k];
            if (load[k] && src_v[k]) begin
                mode_d[k]  = src_m[k];
                carry_d[k] = c;
                sum_d[k]   = s;
                a_d[k]     = (src_a[k] >> ((k + 1) * CHUNK)) << ((k + 1) * CHUNK);
                b_d[k]     = (src_b[k] >> ((k + 1) * CHUNK)) << ((k + 1) * CHUNK);
            end else begin
                sum_d[k]   = sum_q[k];
                a_d[k]     = a_q[k];
                b_d[k]     = b_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            mode_q  <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    assign ready_o  = load[0];
    assign valid_o  = valid_q[STAGES-1];
    assign result_o = {carry_q[STAGES-1], sum_q[STAGES-1]};

endmodule
`default_nettype wire

// File: doc/pipelined_approx_adder.md
# pipelined_approx_adder

Parametrised, pipelined ripple-carry adder with a per-transaction selectable approximate low part (lower-part OR adder). It is the streaming successor to the team's single-cycle ripple-carry adders. Width, pipeline depth and approximate-bit count are set per instance. It sits between operand producers and the accuracy/error-measurement logic. A valid/ready handshake with full backpressure lets exact and approximate results be streamed and compared cycle by cycle.

## Interface
- WIDTH, 16: operand width; result is WIDTH+1 bits.
- STAGES, 4: pipeline stages. Legal range is 1..WIDTH, and WIDTH must be divisible by STAGES. Each stage adds CHUNK = WIDTH/STAGES bits.
- APPROX_BITS, 4: low bits computed approximately in approx mode. Legal range is 0..WIDTH-1; 0 makes approx mode identical to exact.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  operands valid.
- ready_o  output  1  block can accept operands this cycle.
- add1_i  input  WIDTH  operand A.
- add2_i  input  WIDTH  operand B.
- carry_i  input  1  carry-in; used in exact mode only.
- approx_en_i  input  1  1 = approximate mode for this transaction.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- result_o  output  WIDTH+1  {carry-out, sum}.

## Operation
- A transfer occurs on a rising edge with valid_i & ready_o. A result is consumed on a rising edge with valid_o & ready_i.
- The pipeline has stage registers R0..R(STAGES-1). Each Rk holds:
  - a valid bit,
  - the mode bit,
  - the running carry,
  - sum bits [(k+1)*CHUNK-1:0],
  - the unconsumed operand bits [WIDTH-1:(k+1)*CHUNK] (skew registers).
- R(STAGES-1) drives valid_o and result_o directly. No combinational path from inputs to outputs.
- Stage k ripples operand bits [(k+1)*CHUNK-1 : k*CHUNK] with the carry from the previous stage. Stage 0 uses carry_i.
- Exact mode: result_o = add1_i + add2_i + carry_i, full WIDTH+1 bits, no truncation.
- Approx mode, with K = APPROX_BITS:
  - sum[K-1:0] = add1_i[K-1:0] | add2_i[K-1:0];
  - carry into bit K = add1_i[K-1] & add2_i[K-1];
  - bits K..WIDTH-1 are exact ripple;
  - carry_i is ignored;
  - K=0 means exact with carry-in forced to 0.
- The approximate region may span several stages; the OR/AND rule is applied bitwise within whichever stages cover bits below K.
- Mode travels with the data. Changing approx_en_i never affects transactions already in flight.
- Per-stage flow control (bubble-collapsing):
  - Rk loads when it is empty or R(k+1) is loading.
  - R(STAGES-1) loads when it is empty or ready_i is high.
  - Rk clears its valid bit when it hands data on and receives nothing.
  - ready_o = load condition of R0.
- Ordering: strictly in order, no drop, no duplication.

## Timing
- Reset (rst_ni low, asynchronous): all stage valid bits 0, valid_o = 0, result_o = 0, ready_o = 1 after reset deassertion, all data registers 0.
- Reset mid-operation discards all in-flight transactions. The first valid_o after reset belongs to the first post-reset transfer.
- Latency: a transfer on edge N with empty downstream stages gives valid_o high after edge N+STAGES-1. With STAGES=4, that is 4 edges counting the accepting edge.
- Throughput: one transfer per cycle while ready_i stays high.
- Backpressure: while valid_o & !ready_i, result_o and valid_o hold stable. Upstream stages keep filling until every Rk is valid, then ready_o drops. ready_o may depend combinationally on ready_i.
- Simultaneous consume and transfer with a full pipeline: all stages advance in the same cycle and ready_o stays 1.
- valid_i with ready_o low: operands are not captured. The source must hold them (standard valid/ready).

## Test plan
- Exact carry-out: WIDTH=16, STAGES=4, APPROX_BITS=4, approx_en=0, carry_i=0. Drive 0xFFFF + 0x0001 → result_o = 0x10000, valid_o high after edge N+3.
- Carry-in: exact mode, carry_i=1, 0x1234 + 0x1111 → result_o = 0x02346. The same operands in approx mode with carry_i=1 → 0x02345 (carry_i ignored; low nibble 4|1 = 5).
- Approximate rule: approx_en=1.
  - 0x000F + 0x0001 → 0x0000F (exact would be 0x00010).
  - 0x0008 + 0x0008 → 0x00018 (OR = 8, carry into bit 4 = 1).
- Streaming with mode interleave: 8 back-to-back transfers with approx_en toggling each cycle and ready_i=1 → 8 consecutive valid_o cycles, first after edge N+3, each result matching its own mode in order.
- Backpressure: stream continuously with ready_i=0 for 6 cycles.
  - ready_o drops after 4 accepted transfers.
  - result_o stays constant throughout.
  - Releasing ready_i delivers all 4 results in order, then the stream resumes with no loss or duplication.
- Reset mid-flight: 3 transactions in flight, pull rst_ni low asynchronously between edges.
  - valid_o = 0 and result_o = 0 immediately.
  - After release, ready_o = 1 and the next transfer's result is the first output.
